// File: rtl/led_stream_pkg.sv
// Shared types and constants for the framed UART-to-LED-RAM stream router.
package led_stream_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHAN  = 3'd1,
      ST_ADDR  = 3'd2,
      ST_COUNT = 3'd3,
      ST_PIXEL = 3'd4,
      ST_CSUM  = 3'd5
   } lsr_state_e;

   localparam logic [7:0] SYNC_BYTE = 8'hAA;
   localparam int         BPP_RGB   = 3;
   localparam int         BPP_RGBW  = 4;
   localparam logic [7:0] ERR_SAT   = 8'd255;

   // Byte k of a pixel lands in [8k+7:8k]; RGB words keep the top byte zero.
   function automatic logic [31:0] pack_pixel(input logic [23:0] low,
                                              input logic [7:0]  last,
                                              input logic        rgbw);
      if (rgbw) begin
         pack_pixel = {last, low};
      end else begin
         pack_pixel = {8'd0, last, low[15:0]};
      end
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      if (value == ERR_SAT) begin
         sat_inc = value;
      end else begin
         sat_inc = value + 8'd1;
      end
   endfunction

endpackage

// File: rtl/lsr_byte_timeout.sv
// Inter-byte watchdog: counts cycles while enabled, cleared by every received
// byte, and emits a one-cycle expire pulse after TIMEOUT_CYC quiet cycles.
module lsr_byte_timeout
   import led_stream_pkg::*;
#(
   parameter int TIMEOUT_CYC = 50_000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count_r;

   // Quiet-cycle counter; wraps to zero as it fires so the pulse is one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
         expire  <= 1'b0;
      end else if (!enable || clear) begin
         count_r <= {CNT_W{1'b0}};
         expire  <= 1'b0;
      end else if (count_r == LAST_CNT) begin
         count_r <= {CNT_W{1'b0}};
         expire  <= 1'b1;
      end else begin
         count_r <= count_r + CNT_W'(1'b1);
         expire  <= 1'b0;
      end
   end

endmodule

// File: rtl/led_stream_router.sv
// Parses SYNC/CHAN/ADDR/COUNT/pixels[/CSUM] frames and writes packed pixels to
// per-strip RAMs. Define LSR_CHECKSUM_EN to expect and verify a trailing CSUM.
module led_stream_router
   import led_stream_pkg::*;
#(
   parameter int         CHANNELS    = 2,
   parameter int         ADDR_W      = 3,
   parameter logic [7:0] RGBW_MASK   = 8'b0000_0010,
   parameter int         TIMEOUT_CYC = 50_000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [7:0]          rx_data,
   input  logic                rx_ready,
   output logic [31:0]         led_data,
   output logic [ADDR_W-1:0]   led_addr,
   output logic [CHANNELS-1:0] led_write,
   output logic                frame_done,
   output logic                frame_error,
   output logic [7:0]          err_count,
   output logic                busy
);

   lsr_state_e          state_r;
   logic [2:0]          chan_r;
   logic                chan_ok_r;
   logic                rgbw_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [7:0]          count_r;
   logic [1:0]          byte_idx_r;
   logic [23:0]         pix_r;
   logic [7:0]          csum_r;

   logic                expire_s;
   logic                chan_ok_s;
   logic                rgbw_s;
   logic [1:0]          last_idx_s;
   logic [CHANNELS-1:0] sel_s;
   logic [31:0]         pixel_word_s;

   lsr_byte_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .enable (busy),
      .clear  (rx_ready),
      .expire (expire_s)
   );

   // Decode of the incoming channel byte and the current pixel's shape.
   always_comb begin
      chan_ok_s    = (rx_data < 8'(CHANNELS));
      rgbw_s       = chan_ok_s && RGBW_MASK[rx_data[2:0]];
      last_idx_s   = rgbw_r ? 2'(BPP_RGBW - 1) : 2'(BPP_RGB - 1);
      sel_s        = CHANNELS'(1'b1) << chan_r;
      pixel_word_s = pack_pixel(pix_r, rx_data, rgbw_r);
   end

   // Frame parser; every output is registered and pulses last one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         chan_r      <= 3'd0;
         chan_ok_r   <= 1'b0;
         rgbw_r      <= 1'b0;
         addr_r      <= {ADDR_W{1'b0}};
         count_r     <= 8'd0;
         byte_idx_r  <= 2'd0;
         pix_r       <= 24'd0;
         csum_r      <= 8'd0;
         led_data    <= 32'd0;
         led_addr    <= {ADDR_W{1'b0}};
         led_write   <= {CHANNELS{1'b0}};
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         busy        <= 1'b0;
      end else begin
         led_write   <= {CHANNELS{1'b0}};
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         if (rx_ready) begin
            case (state_r)
               ST_IDLE: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_r <= ST_CHAN;
                     busy    <= 1'b1;
                  end
               end
               ST_CHAN: begin
                  chan_r    <= rx_data[2:0];
                  chan_ok_r <= chan_ok_s;
                  rgbw_r    <= rgbw_s;
                  csum_r    <= rx_data;
                  state_r   <= ST_ADDR;
               end
               ST_ADDR: begin
                  addr_r  <= rx_data[ADDR_W-1:0];
                  csum_r  <= csum_r ^ rx_data;
                  state_r <= ST_COUNT;
               end
               ST_COUNT: begin
                  count_r    <= rx_data;
                  csum_r     <= csum_r ^ rx_data;
                  byte_idx_r <= 2'd0;
                  if (rx_data != 8'd0) begin
                     state_r <= ST_PIXEL;
                  end else begin
`ifdef LSR_CHECKSUM_EN
                     state_r <= ST_CSUM;
`else
                     state_r     <= ST_IDLE;
                     busy        <= 1'b0;
                     frame_done  <= chan_ok_r;
                     frame_error <= !chan_ok_r;
`endif
                  end
               end
               ST_PIXEL: begin
                  csum_r <= csum_r ^ rx_data;
                  if (byte_idx_r == last_idx_s) begin
                     // Invalid channels still consume their bytes, silently.
                     if (chan_ok_r) begin
                        led_write <= sel_s;
                        led_data  <= pixel_word_s;
                        led_addr  <= addr_r;
                     end
                     addr_r     <= addr_r + ADDR_W'(1'b1);
                     count_r    <= count_r - 8'd1;
                     byte_idx_r <= 2'd0;
                     if (count_r == 8'd1) begin
`ifdef LSR_CHECKSUM_EN
                        state_r <= ST_CSUM;
`else
                        state_r     <= ST_IDLE;
                        busy        <= 1'b0;
                        frame_done  <= chan_ok_r;
                        frame_error <= !chan_ok_r;
`endif
                     end
                  end else begin
                     case (byte_idx_r)
                        2'd0:    pix_r[7:0]   <= rx_data;
                        2'd1:    pix_r[15:8]  <= rx_data;
                        2'd2:    pix_r[23:16] <= rx_data;
                        default: pix_r        <= pix_r;
                     endcase
                     byte_idx_r <= byte_idx_r + 2'd1;
                  end
               end
               ST_CSUM: begin
                  state_r     <= ST_IDLE;
                  busy        <= 1'b0;
                  frame_done  <= chan_ok_r && (rx_data == csum_r);
                  frame_error <= !(chan_ok_r && (rx_data == csum_r));
               end
               default: begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end else if (expire_s && (state_r != ST_IDLE)) begin
            state_r     <= ST_IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
         end
      end
   end

   // Errored-frame counter, saturating; only reset clears it.
   always_ff @(posedge clock) begin
      if (reset) begin
         err_count <= 8'd0;
      end else if (frame_error) begin
         err_count <= sat_inc(err_count);
      end
   end

endmodule

// File: tb/tb_led_stream_router.sv
// Scoreboard bench for led_stream_router; follows LSR_CHECKSUM_EN if defined.
module tb_led_stream_router;

   localparam int         CHANNELS    = 2;
   localparam int         ADDR_W      = 3;
   localparam logic [7:0] RGBW_MASK   = 8'b0000_0010;
   localparam int         TIMEOUT_CYC = 50_000;
`ifdef LSR_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic [7:0]          rx_data = 8'd0;
   logic                rx_ready = 1'b0;
   logic [31:0]         led_data;
   logic [ADDR_W-1:0]   led_addr;
   logic [CHANNELS-1:0] led_write;
   logic                frame_done;
   logic                frame_error;
   logic [7:0]          err_count;
   logic                busy;

   led_stream_router #(
      .CHANNELS    (CHANNELS),
      .ADDR_W      (ADDR_W),
      .RGBW_MASK   (RGBW_MASK),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .led_data    (led_data),
      .led_addr    (led_addr),
      .led_write   (led_write),
      .frame_done  (frame_done),
      .frame_error (frame_error),
      .err_count   (err_count),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [CHANNELS-1:0] sel;
      logic [ADDR_W-1:0]   addr;
      logic [31:0]         data;
   } wr_t;

   wr_t        wr_q[$];
   logic [1:0] frm_q[$];    // 2'b10 = frame_done, 2'b01 = frame_error
   int         exp_err = 0;
   int         n_vec = 0;
   int         n_err = 0;
   wr_t        mon_wr;
   logic [1:0] mon_frm;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Scoreboard monitor: pop expected writes and frame pulses as the DUT emits them.
   always @(negedge clock) begin
      if (!reset) begin
         if (led_write != '0) begin
            if (wr_q.size() == 0) begin
               check_eq("wr_unexp", 32'(led_write), 32'd0);
            end else begin
               mon_wr = wr_q.pop_front();
               check_eq("wr_sel", 32'(led_write), 32'(mon_wr.sel));
               check_eq("wr_addr", 32'(led_addr), 32'(mon_wr.addr));
               check_eq("wr_data", led_data, mon_wr.data);
            end
         end
         if (frame_done || frame_error) begin
            if (frm_q.size() == 0) begin
               check_eq("frm_unexp", {30'd0, frame_done, frame_error}, 32'd0);
            end else begin
               mon_frm = frm_q.pop_front();
               check_eq("frame", {30'd0, frame_done, frame_error}, {30'd0, mon_frm});
               check_eq("busy_fall", 32'(busy), 32'd0);
            end
         end
      end
   end

   task automatic bump_err();
      if (exp_err < 255) exp_err++;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      @(posedge clock);
      #1;
      rx_ready = 1'b0;
   endtask

   task automatic settle_check();
      repeat (3) @(posedge clock);
      #1;
      check_eq("wr_drain", 32'(wr_q.size()), 32'd0);
      check_eq("frm_drain", 32'(frm_q.size()), 32'd0);
      check_eq("err_count", 32'(err_count), 32'(exp_err));
   endtask

   task automatic send_frame(input int chan, input int addr, input int count,
                             input logic [7:0] seed, input bit bad_cs);
      logic [7:0]  cs;
      logic [7:0]  b;
      logic [31:0] word;
      logic [1:0]  fexp;
      int          a;
      int          bpp;
      int          n;
      bit          ok;
      wr_t         e;
      ok   = (chan < CHANNELS);
      bpp  = (ok && RGBW_MASK[chan]) ? 4 : 3;
      fexp = (ok && !(CS_EN && bad_cs)) ? 2'b10 : 2'b01;
      frm_q.push_back(fexp);
      if (fexp == 2'b01) bump_err();
      cs = chan[7:0] ^ addr[7:0] ^ count[7:0];
      send_byte(8'hAA);
      send_byte(chan[7:0]);
      send_byte(addr[7:0]);
      send_byte(count[7:0]);
      a = addr;
      n = 0;
      for (int p = 0; p < count; p++) begin
         word = 32'd0;
         for (int k = 0; k < bpp; k++) begin
            b = seed + 8'(n * 17);
            n++;
            cs = cs ^ b;
            word[8*k +: 8] = b;
            if (k == bpp - 1 && ok) begin
               e.sel  = CHANNELS'(1) << chan;
               e.addr = ADDR_W'(a);
               e.data = word;
               wr_q.push_back(e);
            end
            send_byte(b);
            if (k == bpp - 1) begin
               check_eq("wr_lat", 32'(led_write), ok ? (32'd1 << chan) : 32'd0);
               a++;
            end
         end
      end
      if (CS_EN) send_byte(bad_cs ? ~cs : cs);
      settle_check();
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_data", led_data, 32'd0);
      check_eq("rst_addr", 32'(led_addr), 32'd0);
      check_eq("rst_write", 32'(led_write), 32'd0);
      check_eq("rst_done", 32'(frame_done), 32'd0);
      check_eq("rst_error", 32'(frame_error), 32'd0);
      check_eq("rst_errcnt", 32'(err_count), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // RGB single pixel, bytes 11 22 33
      send_frame(0, 2, 1, 8'h11, 1'b0);
      check_eq("t1_data", led_data, 32'h00332211);
      check_eq("t1_addr", 32'(led_addr), 32'd2);

      // RGBW block wrapping 6, 7, 0
      send_frame(1, 6, 3, 8'h40, 1'b0);
      check_eq("t2_data", led_data, 32'hFBEAD9C8);
      check_eq("t2_addr", 32'(led_addr), 32'd0);

      // COUNT = 0, and a 0xAA pixel byte treated as data
      send_frame(0, 5, 0, 8'h01, 1'b0);
      send_frame(0, 0, 2, 8'hAA, 1'b0);

`ifdef LSR_CHECKSUM_EN
      send_frame(1, 1, 2, 8'h07, 1'b1);
      check_eq("cs_errcnt", 32'(err_count), 32'd1);
`endif

      // Inter-byte timeout mid-frame
      frm_q.push_back(2'b01);
      bump_err();
      send_byte(8'hAA);
      send_byte(8'h00);
      check_eq("to_busy_hi", 32'(busy), 32'd1);
      repeat (TIMEOUT_CYC + 20) @(posedge clock);
      #1;
      check_eq("to_fired", 32'(frm_q.size()), 32'd0);
      check_eq("to_busy_lo", 32'(busy), 32'd0);
      check_eq("to_errcnt", 32'(err_count), 32'(exp_err));
      send_frame(1, 3, 2, 8'h5A, 1'b0);

      // Invalid channel frames until err_count saturates
      for (int i = 0; i < 300; i++) send_frame(5, 0, 1, 8'h33, 1'b0);
      check_eq("sat_errcnt", 32'(err_count), 32'd255);

      // Garbage in IDLE, then reset in the middle of a pixel
      send_byte(8'h55);
      send_byte(8'h00);
      check_eq("garb_busy", 32'(busy), 32'd0);
      send_byte(8'hAA);
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'h02);
      send_byte(8'h11);
      send_byte(8'h22);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check_eq("mr_data", led_data, 32'd0);
      check_eq("mr_addr", 32'(led_addr), 32'd0);
      check_eq("mr_write", 32'(led_write), 32'd0);
      check_eq("mr_done", 32'(frame_done), 32'd0);
      check_eq("mr_error", 32'(frame_error), 32'd0);
      check_eq("mr_errcnt", 32'(err_count), 32'd0);
      check_eq("mr_busy", 32'(busy), 32'd0);
      reset   = 1'b0;
      exp_err = 0;
      repeat (4) @(posedge clock);
      #1;
      check_eq("mr_no_pulse", 32'(frm_q.size() + wr_q.size()), 32'd0);
      send_frame(0, 1, 1, 8'h21, 1'b0);

      check_eq("end_wr_q", 32'(wr_q.size()), 32'd0);
      check_eq("end_frm_q", 32'(frm_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
